// File: rtl/byte_serial_adder.sv
// Byte-serial W-bit adder: one byte per clock, LSB first, carry chained
// through a register; valid/ready on operand and result sides.
module byte_serial_adder #(
   parameter int NBYTES = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [8*NBYTES-1:0] a_in,
   input  logic [8*NBYTES-1:0] b_in,
   input  logic                cin,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [8*NBYTES-1:0] sum,
   output logic                cout,
   output logic                ovf
);

   localparam int W  = 8 * NBYTES;
   localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

   typedef enum logic [1:0] {
      IDLE,
      ADD,
      DONE
   } state_t;

   state_t        state_q, state_d;
   logic          carry_q, carry_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [W-1:0]  a_sh_q, a_sh_d;
   logic [W-1:0]  b_sh_q, b_sh_d;
   logic [W-1:0]  sum_sh_q, sum_sh_d;
   logic          cout_q, cout_d;
   logic          ovf_q, ovf_d;

   logic [7:0]    rca_s;
   logic          rca_co;
   logic [W+7:0]  sum_cat;

   // 8-bit ripple-carry byte slice
   always_comb begin
      {rca_co, rca_s} = {1'b0, a_sh_q[7:0]}
                      + {1'b0, b_sh_q[7:0]}
                      + {8'b0, carry_q};
   end

   always_comb begin
      state_d  = state_q;
      carry_d  = carry_q;
      cnt_d    = cnt_q;
      a_sh_d   = a_sh_q;
      b_sh_d   = b_sh_q;
      sum_sh_d = sum_sh_q;
      cout_d   = cout_q;
      ovf_d    = ovf_q;
      sum_cat  = {rca_s, sum_sh_q};
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_sh_d  = a_in;
               b_sh_d  = b_in;
               carry_d = cin;
               cnt_d   = '0;
               state_d = ADD;
            end
         end
         ADD: begin
            sum_sh_d = sum_cat[W+7:8];
            carry_d  = rca_co;
            a_sh_d   = a_sh_q >> 8;
            b_sh_d   = b_sh_q >> 8;
            cnt_d    = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               cout_d  = rca_co;
               ovf_d   = (a_sh_q[7] == b_sh_q[7]) &&
                         (rca_s[7] != a_sh_q[7]);
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         carry_q  <= 1'b0;
         cnt_q    <= '0;
         a_sh_q   <= '0;
         b_sh_q   <= '0;
         sum_sh_q <= '0;
         cout_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         carry_q  <= carry_d;
         cnt_q    <= cnt_d;
         a_sh_q   <= a_sh_d;
         b_sh_q   <= b_sh_d;
         sum_sh_q <= sum_sh_d;
         cout_q   <= cout_d;
         ovf_q    <= ovf_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign sum       = sum_sh_q;
   assign cout      = cout_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_byte_serial_adder.sv
// Self-checking bench for byte_serial_adder (NBYTES=4): directed
// corner cases plus randomized adds against an arithmetic model.
module tb_byte_serial_adder;

   localparam int NB = 4;
   localparam int W  = 8 * NB;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] a_in = '0;
   logic [W-1:0] b_in = '0;
   logic         cin = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] sum;
   logic         cout;
   logic         ovf;

   int n_checks = 0;
   int n_fail   = 0;

   byte_serial_adder #(.NBYTES(NB)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .a_in(a_in), .b_in(b_in), .cin(cin),
      .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout), .ovf(ovf)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // Reference: plain W-bit two's-complement add; returns {cout, ovf, sum}
   function automatic logic [W+1:0] model(input logic [W-1:0] a,
                                          input logic [W-1:0] b,
                                          input logic c);
      logic [W:0] full;
      logic       v;
      full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
      v = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
      return {full[W], v, full[W-1:0]};
   endfunction

   // Present operands and hold in_valid until one accepting edge passes
   task automatic start_add(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic c);
      int t = 0;
      while (!in_ready && t < 50) begin
         @(posedge clk); #1; t++;
      end
      a_in = a; b_in = b; cin = c; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      a_in = $urandom; b_in = $urandom; cin = 1'($urandom);
   endtask

   // Edges from acceptance until out_valid; -1 if it never arrives
   task automatic wait_done(output int lat);
      lat = -1;
      for (int k = 1; k <= 20 && lat < 0; k++) begin
         @(posedge clk); #1;
         if (out_valid) lat = k;
      end
   endtask

   task automatic release_result();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1; rst = 1'b0;
      n_checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_hs: in_ready=%b out_valid=%b want 1 0",
                  in_ready, out_valid);
      end
      n_checks++;
      if (sum !== '0 || cout !== 1'b0 || ovf !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_out: sum=%h cout=%b ovf=%b want 0 0 0",
                  sum, cout, ovf);
      end
   endtask

   task automatic test_directed();
      logic [W-1:0] va [5] = '{32'h000000FF, 32'hFFFFFFFF, 32'h7FFFFFFF,
                               32'h80000000, 32'h12345678};
      logic [W-1:0] vb [5] = '{32'h00000001, 32'h00000000, 32'h00000001,
                               32'h80000000, 32'h11111111};
      logic         vc [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      logic [W-1:0] es [5] = '{32'h00000100, 32'h00000000, 32'h80000000,
                               32'h00000000, 32'h2345678A};
      logic         ec [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      logic         eo [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      int lat;
      for (int i = 0; i < 5; i++) begin
         start_add(va[i], vb[i], vc[i]);
         wait_done(lat);
         n_checks++;
         if (lat !== NB) begin
            n_fail++;
            $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, NB);
         end
         n_checks++;
         if (sum !== es[i] || cout !== ec[i] || ovf !== eo[i]) begin
            n_fail++;
            $display("FAIL dir%0d_result: sum=%h cout=%b ovf=%b want %h %b %b",
                     i, sum, cout, ovf, es[i], ec[i], eo[i]);
         end
         release_result();
         n_checks++;
         if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL dir%0d_idle: in_ready=%b out_valid=%b want 1 0",
                     i, in_ready, out_valid);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [W+1:0] exp;
      int lat;
      exp = model(32'h89ABCDEF, 32'h76543210, 1'b1);
      start_add(32'h89ABCDEF, 32'h76543210, 1'b1);
      wait_done(lat);
      in_valid = 1'b1; a_in = 32'h11111111; b_in = 32'h22222222;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk); #1;
         n_checks++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
             {cout, ovf, sum} !== exp) begin
            n_fail++;
            $display("FAIL bp_hold%0d: ov=%b ir=%b res=%h want 1 0 %h",
                     k, out_valid, in_ready, {cout, ovf, sum}, exp);
         end
      end
      in_valid = 1'b0;
      release_result();
      n_checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== exp[W-1:0]) begin
         n_fail++;
         $display("FAIL bp_release: ir=%b ov=%b sum=%h want 1 0 %h",
                  in_ready, out_valid, sum, exp[W-1:0]);
      end
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         n_checks++;
         if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_noaccept%0d: ov=%b ir=%b want 0 1",
                     k, out_valid, in_ready);
         end
      end
   endtask

   task automatic test_reset_abort();
      int lat;
      int seen = 0;
      start_add(32'hDEADBEEF, 32'h01020304, 1'b1);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      n_checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_idle: ir=%b ov=%b want 1 0", in_ready, out_valid);
      end
      for (int k = 0; k < 8; k++) begin
         @(posedge clk); #1;
         if (out_valid) seen++;
      end
      n_checks++;
      if (seen != 0) begin
         n_fail++;
         $display("FAIL abort_no_valid: out_valid seen %0d times want 0", seen);
      end
      start_add(32'h12345678, 32'h11111111, 1'b0);
      wait_done(lat);
      n_checks++;
      if (lat !== NB || sum !== 32'h23456789 || cout !== 1'b0 ||
          ovf !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_next: lat=%0d sum=%h c=%b v=%b want %0d 23456789 0 0",
                  lat, sum, cout, ovf, NB);
      end
      release_result();
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] a, b;
      logic         c;
      logic [W+1:0] exp;
      int lat, hold;
      for (int i = 0; i < 40; i++) begin
         a = $urandom; b = $urandom; c = 1'($urandom);
         if (i % 8 == 0) a = 32'h7FFFFFFF;
         if (i % 8 == 1) b = 32'h80000000;
         exp = model(a, b, c);
         start_add(a, b, c);
         wait_done(lat);
         n_checks++;
         if (lat !== NB || {cout, ovf, sum} !== exp) begin
            n_fail++;
            $display("FAIL rand%0d: lat=%0d res=%h want %0d %h",
                     i, lat, {cout, ovf, sum}, NB, exp);
         end
         hold = $urandom_range(0, 3);
         repeat (hold) begin
            @(posedge clk); #1;
         end
         n_checks++;
         if (out_valid !== 1'b1 || {cout, ovf, sum} !== exp) begin
            n_fail++;
            $display("FAIL rand%0d_hold: ov=%b res=%h want 1 %h",
                     i, out_valid, {cout, ovf, sum}, exp);
         end
         release_result();
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_backpressure();
      test_reset_abort();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
